seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The block SHALL have parameter PAT_W, default 6, meaning pattern length in bits (2..16).
REQ-002 The block SHALL have parameter PATTERN, default 6'b110101, meaning the bit pattern transmitted MSB first.
REQ-003 The block SHALL have parameter CNT_W, default 4, meaning the width of the repeat and gap fields.
REQ-004 Port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: request a transmission burst; sampled only in IDLE.
REQ-007 Port count, input, CNT_W bits: number of pattern copies in the burst; latched on accepted start.
REQ-008 Port gap, input, CNT_W bits: number of zero bits inserted between consecutive copies; latched on accepted start.
REQ-009 Port abort, input, 1 bit: terminate the burst in progress.
REQ-010 Port op, output, 1 bit: serial data out.
REQ-011 Port op_valid, output, 1 bit: op carries a burst bit (pattern or gap) this cycle.
REQ-012 Port busy, output, 1 bit: burst in progress (SEND or GAP state).
REQ-013 Port done, output, 1 bit: single-cycle pulse on normal burst completion.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, GAP and DONE, with outputs decoded from registered state only (Moore).
REQ-015 In IDLE: op=0, op_valid=0, busy=0, done=0.
REQ-016 In IDLE with start=1 and count!=0: latch count into reps and gap into gap_len, set bit index to PAT_W-1, go to SEND.
REQ-017 In IDLE with start=1 and count==0: go to DONE with no bits sent.
REQ-018 In SEND: op=PATTERN[index], op_valid=1, busy=1, and the index decrements each cycle.
REQ-019 In SEND at index 0 with reps==1: go to DONE.
REQ-020 In SEND at index 0 with reps>1: decrement reps, then go to SEND with index PAT_W-1 if gap_len==0, else go to GAP with the gap counter set to gap_len.
REQ-021 In GAP: op=0, op_valid=1, busy=1; stay exactly gap_len cycles, then go to SEND with index PAT_W-1.
REQ-022 In DONE: done=1, op=0, op_valid=0, busy=0; go to IDLE unconditionally on the next cycle.
REQ-023 start SHALL be ignored in SEND, GAP and DONE, and changes to count and gap after acceptance SHALL have no effect.
REQ-024 Latency: with start accepted at edge N, the first pattern bit SHALL appear in the cycle following edge N.
REQ-025 A burst SHALL occupy count*PAT_W + (count-1)*gap cycles of op_valid=1, followed immediately by one done cycle.
REQ-026 abort=1 in SEND or GAP SHALL force IDLE at the next edge with no done pulse; abort SHALL be ignored in IDLE and DONE.
REQ-027 If start and abort are both high in IDLE, start SHALL win.
REQ-028 Maximum count and gap values (2^CNT_W-1) SHALL be handled with no counter wrap-around.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and clear index, reps and gap counters, giving op=0, op_valid=0, busy=0, done=0 from the next cycle.
REQ-030 rst SHALL take priority over abort and start, including mid-burst, and SHALL NOT produce a done pulse.
REQ-031 The first start SHALL be accepted in the cycle after rst is released.

Verification
REQ-032 start, count=1, gap=0 -> op = 1,1,0,1,0,1 on 6 consecutive op_valid cycles, then done=1 for 1 cycle, then IDLE.
REQ-033 count=2, gap=2 -> op stream 110101 00 110101 over 14 valid cycles, done in the 15th cycle after start.
REQ-034 count=0 -> done=1 in the cycle after start, op_valid never asserted, busy never asserted.
REQ-035 count=3, gap=0, with op fed to a 110101 sequence detector -> 18 valid bits and exactly 3 detections, at bits 6, 12 and 18.
REQ-036 abort asserted during the 3rd bit of copy 2 (count=4) -> op_valid=0 and busy=0 from the next cycle, no done pulse, and a new start is accepted on the following cycle.
REQ-037 rst asserted during GAP (count=2, gap=3) -> all outputs 0 the next cycle, and start pulses during rst are ignored.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern burst transmitter: sends PATTERN (MSB first) count times, gap zero bits between copies.
// Latency: first pattern bit on op in the cycle after start is accepted; done pulses the cycle after the last bit.
// Backpressure: none; start is only sampled in IDLE, and abort drops an active burst without a done pulse.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, count, gap burst request; count copies with gap zero bits between copies (latched on accept)
//   abort             kills a burst in SEND/GAP; ignored in IDLE/DONE; start wins in IDLE
//   op, op_valid      serial bit and its qualifier (pattern or gap bit)
//   busy, done        burst in progress / one-cycle completion pulse
module seq_pattern_tx #(
    parameter int               PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b110101,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] gap,
    input  logic             abort,
    output logic             op,
    output logic             op_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state, n_state;
    logic [IDX_W-1:0] idx, n_idx;
    logic [CNT_W-1:0] reps, n_reps;         // copies still owed, including the one being sent
    logic [CNT_W-1:0] gap_len, n_gap_len;   // latched gap length for the whole burst
    logic [CNT_W-1:0] gcnt, n_gcnt;         // gap cycles remaining, including the current one

    // Next-state logic. Counters only ever count down from latched values,
    // so the all-ones count/gap cases cannot wrap.
    always_comb begin
        n_state   = state;
        n_idx     = idx;
        n_reps    = reps;
        n_gap_len = gap_len;
        n_gcnt    = gcnt;
        case (state)
            IDLE: begin
                // start is checked before anything else so it beats a concurrent abort
                if (start) begin
                    if (count != '0) begin
                        n_state   = SEND;
                        n_idx     = IDX_TOP;
                        n_reps    = count;
                        n_gap_len = gap;
                    end else begin
                        n_state = DONE;
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    n_state = IDLE;
                end else if (idx == '0) begin
                    if (reps == CNT_W'(1)) begin
                        n_state = DONE;
                    end else begin
                        n_reps = reps - CNT_W'(1);
                        if (gap_len == '0) begin
                            n_idx = IDX_TOP;
                        end else begin
                            n_state = GAP;
                            n_gcnt  = gap_len;
                        end
                    end
                end else begin
                    n_idx = idx - IDX_W'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    n_state = IDLE;
                end else if (gcnt <= CNT_W'(1)) begin
                    n_state = SEND;
                    n_idx   = IDX_TOP;
                end else begin
                    n_gcnt = gcnt - CNT_W'(1);
                end
            end
            DONE: begin
                n_state = IDLE;
            end
            default: begin
                n_state = IDLE;
            end
        endcase
    end

    // State and outputs share one register stage: outputs are decoded from
    // the state being entered, so they line up with the registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            reps     <= '0;
            gap_len  <= '0;
            gcnt     <= '0;
            op       <= 1'b0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= n_state;
            idx      <= n_idx;
            reps     <= n_reps;
            gap_len  <= n_gap_len;
            gcnt     <= n_gcnt;
            op       <= (n_state == SEND) && PATTERN[n_idx];
            op_valid <= (n_state == SEND) || (n_state == GAP);
            busy     <= (n_state == SEND) || (n_state == GAP);
            done     <= (n_state == DONE);
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized self-checking bench for seq_pattern_tx against a bit-stream reference model.
// All inputs are driven and all outputs sampled on the falling edge of clk.
// Each burst's expected op stream is built from count/gap and compared cycle by cycle.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] count;
    logic [3:0] gap;
    logic       abort;
    logic       op;
    logic       op_valid;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] pat = 6'b110101;

    // Sequence detector on the valid serial stream
    logic [5:0] det_sh;
    int         det_bits;
    int         det_pos[$];

    seq_pattern_tx dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count    (count),
        .gap      (gap),
        .abort    (abort),
        .op       (op),
        .op_valid (op_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (op_valid === 1'b1) begin
            det_sh = {det_sh[4:0], op};
            det_bits++;
            if (det_bits >= 6 && det_sh == 6'b110101) det_pos.push_back(det_bits);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs packed as {op_valid, busy, done, op}
    function automatic logic [3:0] outs();
        return {op_valid, busy, done, op};
    endfunction

    // Called at a falling edge with the DUT in IDLE. kill_at >= 0 selects the
    // stream bit during which abort (kill_rst=0) or rst (kill_rst=1) is raised.
    // Returns at a falling edge with the DUT in IDLE and start low.
    task automatic burst(input int cnt, input int gp, input int kill_at, input bit kill_rst);
        logic q[$];
        int   name_id;
        name_id = cnt * 100 + gp;
        for (int c = 0; c < cnt; c++) begin
            for (int b = 5; b >= 0; b--) q.push_back(pat[b]);
            if (c < cnt - 1) for (int g = 0; g < gp; g++) q.push_back(1'b0);
        end
        start = 1'b1;
        count = 4'(cnt);
        gap   = 4'(gp);
        abort = 1'($urandom_range(0, 1));   // start must win over abort in IDLE
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            chk($sformatf("b%0d_bit%0d", name_id, k), 32'(outs()), {28'd0, 1'b1, 1'b1, 1'b0, q[k]});
            // Late start/count/gap changes must be ignored
            start = 1'($urandom_range(0, 1));
            count = 4'($urandom);
            gap   = 4'($urandom);
            abort = 1'b0;
            if (k == kill_at) begin
                if (kill_rst) begin
                    rst   = 1'b1;
                    start = 1'b1;
                    abort = 1'b1;
                    for (int r = 0; r < 2; r++) begin
                        @(negedge clk);
                        chk($sformatf("b%0d_rst%0d", name_id, r), 32'(outs()), 32'd0);
                    end
                    rst   = 1'b0;
                    abort = 1'b0;
                    start = 1'b0;
                end else begin
                    abort = 1'b1;
                    @(negedge clk);
                    chk($sformatf("b%0d_abort", name_id), 32'(outs()), 32'd0);
                    abort = 1'b0;
                    start = 1'b0;
                end
                return;
            end
        end
        @(negedge clk);
        chk($sformatf("b%0d_done", name_id), 32'(outs()), 32'b0010);
        start = 1'b0;
        abort = 1'($urandom_range(0, 1));   // ignored in DONE
        @(negedge clk);
        chk($sformatf("b%0d_idle", name_id), 32'(outs()), 32'd0);
        abort = 1'b0;
    endtask

    initial begin
        int cnt;
        int gp;
        int len;
        int kill;
        rst      = 1'b1;
        start    = 1'b1;
        count    = 4'd3;
        gap      = 4'd0;
        abort    = 1'b0;
        det_sh   = '0;
        det_bits = 0;
        repeat (3) @(negedge clk);
        chk("reset", 32'(outs()), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 32'(outs()), 32'd0);

        // Single copy, then two copies with a gap
        burst(1, 0, -1, 1'b0);
        burst(2, 2, -1, 1'b0);
        // Zero count: done next cycle, nothing valid
        burst(0, 5, -1, 1'b0);

        // Three back-to-back copies through the detector
        det_bits = 0;
        det_sh   = '0;
        det_pos.delete();
        burst(3, 0, -1, 1'b0);
        chk("det_bits", 32'(det_bits), 32'd18);
        chk("det_count", 32'(det_pos.size()), 32'd3);
        if (det_pos.size() == 3) begin
            chk("det_pos0", 32'(det_pos[0]), 32'd6);
            chk("det_pos1", 32'(det_pos[1]), 32'd12);
            chk("det_pos2", 32'(det_pos[2]), 32'd18);
        end

        // Abort on the 3rd bit of copy 2, then an immediate restart
        burst(4, 1, 6 + 1 + 2, 1'b0);
        burst(1, 0, -1, 1'b0);

        // Reset during the gap, start held high through reset, start right after release
        burst(2, 3, 6 + 1, 1'b1);
        burst(1, 0, -1, 1'b0);

        // Largest count and gap
        burst(15, 15, -1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            cnt  = $urandom_range(0, 15);
            gp   = $urandom_range(0, 15);
            len  = (cnt == 0) ? 0 : cnt * 6 + (cnt - 1) * gp;
            kill = -1;
            if (len > 0 && $urandom_range(0, 3) == 0) kill = $urandom_range(0, len - 1);
            burst(cnt, gp, kill, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
